seg_edit_scroll: RTL and testbench
==================================

# seg_edit_scroll

Parametrised multi-digit hex editor and scroller driving a multiplexed 7-segment display. Four debounced push-buttons edit the digit under a cursor: increment, decrement, cursor-left, cursor-right. A scroll mode rotates the digit string at a fixed rate. The block sits between the board switches/buttons and the display pins, and generalises the fixed 4-digit add/left display to N digits, bidirectional editing, debouncing and timed scrolling.

## Interface
Parameters:
- DIGITS, 4: number of display digits (2..8).
- DEB_CYCLES, 1_000_000: consecutive stable cycles required to accept a button level (≥2).
- SCAN_DIV, 100_000: cycles each digit is driven before the scan advances (≥1).
- SCROLL_DIV, 50_000_000: cycles between scroll rotations (≥2).

Ports (`CW = $clog2(DIGITS)`):
- clk100mhz  in  1  system clock, the only clock.
- clr  in  1  reset, asynchronous and active-high.
- sw_add  in  1  raw button: increment the cursor digit.
- sw_sub  in  1  raw button: decrement the cursor digit.
- sw_left  in  1  raw button: move the cursor one digit left.
- sw_right  in  1  raw button: move the cursor one digit right.
- enable  in  1  level input: 1 = scroll mode, 0 = edit mode. Synchronised with 2 flops; not debounced.
- pos  out  DIGITS  one-hot digit select, active-high. Bit i drives digit i; digit 0 is the rightmost.
- seg  out  8  segments, active-low. Bit 7 = dp, bits 6:0 = g..a.
- cursor  out  CW  current cursor index.

## Operation
- **State:**
  - `val[DIGITS]` holds 4-bit digits; all are 0 after reset.
  - `cursor` is 0 after reset.
  - `scan_idx` is 0 after reset.
  - All prescaler counters are 0 after reset.
- **Button conditioning:** each raw button goes through a 2-flop synchroniser, then a debouncer.
  - The debounced level flips only after the synchronised input has differed from it for DEB_CYCLES consecutive cycles.
  - A flip on a rising edge produces a 1-cycle pulse. Releases produce nothing.
- **Edit mode (synchronised `enable` = 0):**
  - add pulse: `val[cursor]` increments mod 16 (F→0).
  - sub pulse: `val[cursor]` decrements mod 16 (0→F).
  - add and sub in the same cycle: the digit is unchanged.
  - left pulse: `cursor` becomes `cursor+1`, wrapping DIGITS-1→0.
  - right pulse: `cursor` becomes `cursor-1`, wrapping 0→DIGITS-1.
  - left and right in the same cycle: the cursor is unchanged.
  - A digit edit and a cursor move in the same cycle: the edit applies at the old cursor.
- **Scroll mode (synchronised `enable` = 1):**
  - All button pulses are discarded. Debouncers keep running.
  - The scroll counter counts 0..SCROLL_DIV-1. On wrap, the string rotates left: `val[i] ← val[i-1]` and `val[0] ← val[DIGITS-1]`.
  - The scroll counter clears whenever `enable` is 0, so the first rotation comes SCROLL_DIV cycles after entering scroll mode.
  - The cursor is held.
- **Scan:**
  - The scan counter counts 0..SCAN_DIV-1. On wrap, `scan_idx` increments mod DIGITS.
  - `pos = 1 << scan_idx`.
  - `seg[6:0]` is the hex decode of `val[scan_idx]`: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (values include dp=1).
  - `seg[7]` is 0 (dp lit) only when `scan_idx == cursor` and mode = edit.

## Timing
- Reset values while `clr` is high: `pos = 1`, `seg = 8'h40` (digit 0 shows 0, dp lit because cursor 0 is in edit mode), `cursor = 0`.
- Outputs `pos`, `seg` and `cursor` are registered.
- `seg`/`pos` reflect a `val`, `cursor` or `scan_idx` change 1 cycle later.
- Button latency: a raw rise sampled at edge 0, held stable, updates `val`/`cursor` at edge DEB_CYCLES+3.
- A glitch shorter than DEB_CYCLES cycles produces no pulse.
- Holding a button produces exactly one pulse (no auto-repeat).
- A mode change takes effect 2 cycles after the `enable` edge (synchroniser delay).
- A pulse arriving in the same cycle as the mode switch to scroll is discarded.
- `clr` asserted mid-operation returns every register to its reset value immediately. Debouncer state resets to "released", so a button held through reset produces no pulse until it is released and pressed again.

## Structure
- Package `seg_pkg`: the hex→segment constant function, `SEG_DP_BIT = 7`, and the blank pattern `8'hFF`.
- Sub-module `btn_debounce` (synchroniser + stable counter + rise pulse; parameter DEB_CYCLES), instantiated 4 times.
- Top level holds the digit array, cursor, scroll and scan prescalers, and the output registers.

## Test plan
All scenarios use DIGITS=4, DEB_CYCLES=4, SCAN_DIV=2, SCROLL_DIV=16.
1. Reset then idle, observed over 8 cycles → `pos` cycles 1,2,4,8 every 2 cycles. `seg` is C0 on all digits except 40 on digit 0.
2. Four clean sw_add presses (held 10 cycles each) → `val[0] = 4`; digit 0 shows 99 with dp lit (seg = 19). Then five sw_sub presses → `val[0] = F`.
3. sw_left pressed 5 times → `cursor` goes 1,2,3,0,1. sw_right pressed twice → 0, then 3.
4. sw_add toggled at 1-cycle intervals for 20 cycles (bounce) then held → exactly one increment, at DEB_CYCLES+3 edges after the last stable rise.
5. Load `val` = {3,2,1,0} (digits 3..0), then `enable` = 1 → after 16+2 cycles `val` = {2,1,0,3}. sw_add pressed during scroll → no change. dp dark throughout.
6. `clr` pulsed while a button is held and mid-scroll → outputs return to their reset values. Still no pulse after `clr` falls while the button stays held; one pulse after release and re-press.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and the hex-to-7-segment decode for the digit editor.
package seg_pkg;

    localparam int unsigned SEG_DP_BIT = 7;
    localparam logic [7:0]  SEG_BLANK  = 8'hFF;

    // Active-low segment pattern with dp dark.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
        logic [7:0] s;
        case (hex)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            4'hF: s = 8'h8E;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchroniser -> stable-count debouncer -> 1-cycle press pulse.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             vld1_q, vld2_q;
    logic             lvl_q, lvl_d;
    logic             prev_q;
    logic             armed_q, armed_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Pulses stay disarmed until a genuine release is seen after reset,
    // so a button held through reset cannot fire.
    always_comb begin
        cnt_d   = '0;
        lvl_d   = lvl_q;
        if (sync2_q != lvl_q) begin
            if (cnt_q == CNT_MAX) begin
                lvl_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        armed_d = armed_q | (vld2_q & ~sync2_q & ~lvl_q);
        pulse_d = armed_q & lvl_q & ~prev_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            vld1_q  <= 1'b0;
            vld2_q  <= 1'b0;
            lvl_q   <= 1'b0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            vld1_q  <= 1'b1;
            vld2_q  <= vld1_q;
            lvl_q   <= lvl_d;
            prev_q  <= lvl_q;
            armed_q <= armed_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/seg_edit_scroll.sv
// N-digit hex editor/scroller driving a multiplexed active-low 7-segment display.
module seg_edit_scroll
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned DEB_CYCLES = 1_000_000,
    parameter int unsigned SCAN_DIV   = 100_000,
    parameter int unsigned SCROLL_DIV = 50_000_000
) (
    input  logic                       clk100mhz,
    input  logic                       clr,
    input  logic                       sw_add,
    input  logic                       sw_sub,
    input  logic                       sw_left,
    input  logic                       sw_right,
    input  logic                       enable,
    output logic [DIGITS-1:0]          pos,
    output logic [7:0]                 seg,
    output logic [$clog2(DIGITS)-1:0]  cursor
);

    localparam int unsigned CW       = $clog2(DIGITS);
    localparam int unsigned SCAN_W   = $clog2(SCAN_DIV + 1);
    localparam int unsigned SCROLL_W = $clog2(SCROLL_DIV);
    localparam logic [CW-1:0]       CUR_MAX    = CW'(DIGITS - 1);
    localparam logic [SCAN_W-1:0]   SCAN_MAX   = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCROLL_W-1:0] SCROLL_MAX = SCROLL_W'(SCROLL_DIV - 1);

    logic p_add, p_sub, p_left, p_right;
    logic en1_q, en2_q;

    logic [DIGITS-1:0][3:0] val_q, val_d;
    logic [CW-1:0]          cur_q, cur_d;
    logic [CW-1:0]          sidx_q, sidx_d;
    logic [SCAN_W-1:0]      scan_cnt_q, scan_cnt_d;
    logic [SCROLL_W-1:0]    scroll_cnt_q, scroll_cnt_d;
    logic [DIGITS-1:0]      pos_q, pos_d;
    logic [7:0]             seg_q, seg_d;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_add (
        .clk_i(clk100mhz), .rst_i(clr), .btn_i(sw_add), .pulse_o(p_add));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sub (
        .clk_i(clk100mhz), .rst_i(clr), .btn_i(sw_sub), .pulse_o(p_sub));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
        .clk_i(clk100mhz), .rst_i(clr), .btn_i(sw_left), .pulse_o(p_left));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
        .clk_i(clk100mhz), .rst_i(clr), .btn_i(sw_right), .pulse_o(p_right));

    always_comb begin
        val_d        = val_q;
        cur_d        = cur_q;
        sidx_d       = sidx_q;
        scan_cnt_d   = scan_cnt_q + SCAN_W'(1);
        scroll_cnt_d = '0;

        if (scan_cnt_q == SCAN_MAX) begin
            scan_cnt_d = '0;
            sidx_d     = (sidx_q == CUR_MAX) ? '0 : sidx_q + CW'(1);
        end

        // Scroll mode rotates left and ignores buttons; edit mode applies pulses at the old cursor.
        if (en2_q) begin
            if (scroll_cnt_q == SCROLL_MAX) begin
                val_d = {val_q[DIGITS-2:0], val_q[DIGITS-1]};
            end else begin
                scroll_cnt_d = scroll_cnt_q + SCROLL_W'(1);
            end
        end else begin
            if (p_add && !p_sub) begin
                val_d[cur_q] = val_q[cur_q] + 4'd1;
            end else if (p_sub && !p_add) begin
                val_d[cur_q] = val_q[cur_q] - 4'd1;
            end
            if (p_left && !p_right) begin
                cur_d = (cur_q == CUR_MAX) ? '0 : cur_q + CW'(1);
            end else if (p_right && !p_left) begin
                cur_d = (cur_q == '0) ? CUR_MAX : cur_q - CW'(1);
            end
        end

        pos_d             = DIGITS'(1) << sidx_q;
        seg_d             = hex_to_seg(val_q[sidx_q]);
        seg_d[SEG_DP_BIT] = ~((sidx_q == cur_q) & ~en2_q);
    end

    always_ff @(posedge clk100mhz or posedge clr) begin
        if (clr) begin
            en1_q        <= 1'b0;
            en2_q        <= 1'b0;
            val_q        <= '0;
            cur_q        <= '0;
            sidx_q       <= '0;
            scan_cnt_q   <= '0;
            scroll_cnt_q <= '0;
            pos_q        <= DIGITS'(1);
            seg_q        <= 8'h40;
        end else begin
            en1_q        <= enable;
            en2_q        <= en1_q;
            val_q        <= val_d;
            cur_q        <= cur_d;
            sidx_q       <= sidx_d;
            scan_cnt_q   <= scan_cnt_d;
            scroll_cnt_q <= scroll_cnt_d;
            pos_q        <= pos_d;
            seg_q        <= seg_d;
        end
    end

    assign pos    = pos_q;
    assign seg    = seg_q;
    assign cursor = cur_q;

endmodule

// File: tb/tb_seg_edit_scroll.sv
// Randomised scoreboard bench for seg_edit_scroll against a history-based reference model.
module tb_seg_edit_scroll;

    localparam int DIG  = 4;
    localparam int DEB  = 4;
    localparam int SCAN = 2;
    localparam int SCR  = 16;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] btn;        // 0 add, 1 sub, 2 left, 3 right
    logic       enable;
    logic [3:0] pos;
    logic [7:0] seg;
    logic [1:0] cursor;

    seg_edit_scroll #(
        .DIGITS(DIG), .DEB_CYCLES(DEB), .SCAN_DIV(SCAN), .SCROLL_DIV(SCR)
    ) dut (
        .clk100mhz(clk), .clr(clr),
        .sw_add(btn[0]), .sw_sub(btn[1]), .sw_left(btn[2]), .sw_right(btn[3]),
        .enable(enable), .pos(pos), .seg(seg), .cursor(cursor)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] pos;
        logic [7:0] seg;
        logic [1:0] cur;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference state: per-edge histories since the last reset (index = edge number).
    bit         rh [4][$];  // raw button sampled at each edge
    bit         lh [4][$];  // accepted (debounced) level after each edge
    bit         ah [4][$];  // armed after each edge
    bit         ph [4][$];  // press pulse visible after each edge
    bit         eh [$];     // raw enable sampled at each edge
    logic [3:0] mval [DIG];
    int         mcur;
    int         k;
    int         run;

    function automatic bit ysync(int b, int j);
        return (j >= 3) ? rh[b][j-2] : 1'b0;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            rh[b] = {1'b0}; lh[b] = {1'b0}; ah[b] = {1'b0}; ph[b] = {1'b0};
        end
        eh = {1'b0};
        for (int i = 0; i < DIG; i++) mval[i] = 4'd0;
        mcur = 0; k = 0; run = 0;
    endtask

    task automatic model_step();
        int         m, sidx, c;
        bit         lp, flip, pl, pa, ps, pr, pn;
        logic [3:0] tmp;
        exp_t       e;
        k++;
        for (int b = 0; b < 4; b++) rh[b].push_back(btn[b]);
        eh.push_back(enable);
        m    = (k >= 3) ? int'(eh[k-2]) : 0;
        sidx = ((k - 1) / SCAN) % DIG;
        e.pos = 4'(1 << sidx);
        e.seg = hex_tab[mval[sidx]];
        e.seg[7] = !(sidx == mcur && m == 0);
        for (int b = 0; b < 4; b++) begin
            lp   = lh[b][k-1];
            flip = 1'b1;
            for (int j = k - DEB + 1; j <= k; j++) if (ysync(b, j) == lp) flip = 1'b0;
            lh[b].push_back(flip ? !lp : lp);
            ah[b].push_back(ah[b][k-1] || (k >= 3 && ysync(b, k) == 1'b0 && !lp));
            pn = 1'b0;
            if (k >= 2) pn = ah[b][k-1] && lh[b][k-1] && !lh[b][k-2];
            ph[b].push_back(pn);
        end
        pa = ph[0][k-1]; ps = ph[1][k-1]; pl = ph[2][k-1]; pr = ph[3][k-1];
        if (m == 0) begin
            run = 0;
            c   = mcur;
            if (pa && !ps) mval[c] = mval[c] + 4'd1;
            if (ps && !pa) mval[c] = mval[c] - 4'd1;
            if (pl && !pr) mcur = (c + 1) % DIG;
            if (pr && !pl) mcur = (c + DIG - 1) % DIG;
        end else begin
            run++;
            if (run % SCR == 0) begin
                tmp = mval[DIG-1];
                for (int i = DIG - 1; i > 0; i--) mval[i] = mval[i-1];
                mval[0] = tmp;
            end
        end
        e.cur = 2'(mcur);
        sbq.push_back(e);
    endtask

    // Model: one expected output word per clock edge.
    always @(posedge clk) begin
        if (clr) begin
            model_reset();
            sbq.push_back('{pos: 4'b0001, seg: 8'h40, cur: 2'd0});
        end else begin
            model_step();
        end
    end

    // Monitor: compares registered outputs just after each edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty t=%0t", $time);
        end else begin
            e = sbq.pop_front();
            if (pos !== e.pos || seg !== e.seg || cursor !== e.cur) begin
                errors++;
                $display("FAIL outputs t=%0t pos=%b exp %b seg=%h exp %h cursor=%0d exp %0d",
                         $time, pos, e.pos, seg, e.seg, cursor, e.cur);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] m, input int hold, input int gap);
        btn = btn | m;
        cyc(hold);
        btn = btn & ~m;
        cyc(gap);
    endtask

    initial begin
        int act;
        logic [3:0] m;
        btn = 4'b0; enable = 1'b0; clr = 1'b1;
        cyc(3);
        clr = 1'b0;
        cyc(8);
        repeat (4) press(4'b0001, 10, 10);
        repeat (5) press(4'b0010, 10, 10);
        repeat (5) press(4'b0100, 10, 10);
        repeat (2) press(4'b1000, 10, 10);
        for (int i = 0; i < 20; i++) begin
            btn[0] = ~btn[0];
            cyc(1);
        end
        press(4'b0001, 12, 10);
        press(4'b0011, 10, 10);
        press(4'b1100, 10, 10);
        enable = 1'b1;
        cyc(40);
        press(4'b0001, 10, 10);
        enable = 1'b0;
        cyc(10);
        enable = 1'b1;
        btn[0] = 1'b1;
        cyc(10);
        clr = 1'b1;
        cyc(2);
        clr = 1'b0;
        enable = 1'b0;
        cyc(20);
        btn[0] = 1'b0;
        cyc(10);
        press(4'b0001, 10, 10);

        for (int it = 0; it < 120; it++) begin
            act = $urandom_range(0, 11);
            m   = 4'(1 << $urandom_range(0, 3));
            case (act)
                0, 1, 2, 3, 4: press(m, $urandom_range(6, 14), $urandom_range(6, 12));
                5: press(m | 4'(1 << $urandom_range(0, 3)), $urandom_range(6, 12), $urandom_range(6, 12));
                6: begin
                    repeat ($urandom_range(2, 9)) begin
                        btn = btn ^ m;
                        cyc($urandom_range(1, 2));
                    end
                    press(m, 8, 8);
                end
                7: press(m, $urandom_range(1, 3), 8);
                8, 9: begin
                    enable = ~enable;
                    cyc($urandom_range(3, 40));
                end
                10: begin
                    btn = btn | m;
                    cyc($urandom_range(2, 10));
                    clr = 1'b1;
                    cyc($urandom_range(1, 3));
                    clr = 1'b0;
                    cyc($urandom_range(5, 15));
                    btn = 4'b0;
                    cyc(8);
                end
                default: cyc($urandom_range(1, 20));
            endcase
        end
        enable = 1'b0;
        btn = 4'b0;
        cyc(20);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
